piso_shift_tx: RTL and testbench

Parallel-in, serial-out transmitter. It is the sending end for the serial-in `shift_reg` receiver.
- Accepts an N-bit word through a valid/ready load handshake.
- Shifts the word out one bit per clock-enable qualified cycle on `q`, with a qualifying `q_valid` strobe and an end-of-word `done` pulse.
- Sits in front of `shift_reg`, or any serial sink sampling on `ce`.

---
 rtl/piso_shift_tx.sv | 101 ++++++++++
 tb/tb_piso_shift_tx.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: accepts a word on a valid/ready
// handshake and sends it one bit per ce strobe on q, qualified by q_valid,
// with a one-cycle done pulse once the final bit has been consumed.
//
// state | meaning
// IDLE  | no word in flight, q/q_valid/busy low, ready for a load
// SHIFT | a word is being presented on q, one bit per ce strobe
module piso_shift_tx #(
    parameter int N         = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic         load_valid,
    input  logic [N-1:0] din,
    output logic         load_ready,
    output logic         q,
    output logic         q_valid,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(N);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t         state;
    // sreg holds only the bits still waiting behind the one already on q,
    // aligned so the next bit to send always sits at the output end.
    logic [N-1:0]   sreg;
    logic [CW-1:0]  cnt;

    logic           last_bit;
    logic           load;
    logic           first_bit;
    logic [N-1:0]   load_rest;
    logic           next_bit;
    logic [N-1:0]   sreg_shifted;

    assign last_bit   = (state == SHIFT) && ce && (cnt == '0);
    assign load_ready = (state == IDLE) || last_bit;
    assign load       = load_valid && load_ready;

    // Bit-order selection: which din bit goes first and how the remainder moves.
    generate
        if (MSB_FIRST) begin : g_msb
            assign first_bit    = din[N-1];
            assign load_rest    = {din[N-2:0], 1'b0};
            assign next_bit     = sreg[N-1];
            assign sreg_shifted = {sreg[N-2:0], 1'b0};
        end else begin : g_lsb
            assign first_bit    = din[0];
            assign load_rest    = {1'b0, din[N-1:1]};
            assign next_bit     = sreg[0];
            assign sreg_shifted = {1'b0, sreg[N-1:1]};
        end
    endgenerate

    // Sequencer: load, shift on ce, finish word; a load on the last bit chains words gaplessly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            sreg    <= '0;
            cnt     <= '0;
            q       <= 1'b0;
            q_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                sreg    <= load_rest;
                q       <= first_bit;
                q_valid <= 1'b1;
                busy    <= 1'b1;
                cnt     <= CW'(N - 1);
                state   <= SHIFT;
                if (last_bit) begin
                    done <= 1'b1;
                end
            end else if (state == SHIFT && ce) begin
                if (cnt == '0) begin
                    done    <= 1'b1;
                    state   <= IDLE;
                    q       <= 1'b0;
                    q_valid <= 1'b0;
                    busy    <= 1'b0;
                end else begin
                    sreg <= sreg_shifted;
                    q    <= next_bit;
                    cnt  <= cnt - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: an MSB-first and an LSB-first instance share all
// inputs and are checked every cycle against a bit-queue reference model.
module tb_piso_shift_tx;

    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic         ce;
    logic         load_valid;
    logic [N-1:0] din;
    logic         lr_m, q_m, qv_m, busy_m, done_m;
    logic         lr_l, q_l, qv_l, busy_l, done_l;

    int n_cmp;
    int n_bad;

    // Reference model: bits still to be presented, head = bit currently on q.
    bit qm[$];
    bit ql[$];
    bit exp_done;

    logic [1:0] obs_ready, exp_ready;
    logic [7:0] obs_out, exp_out;

    // Loopback receiver: serial-in shift register sampling on ce = q_valid.
    logic [N-1:0] lb_sr;

    piso_shift_tx #(.N(N), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .ce(ce), .load_valid(load_valid), .din(din),
        .load_ready(lr_m), .q(q_m), .q_valid(qv_m), .busy(busy_m), .done(done_m)
    );

    piso_shift_tx #(.N(N), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .ce(ce), .load_valid(load_valid), .din(din),
        .load_ready(lr_l), .q(q_l), .q_valid(qv_l), .busy(busy_l), .done(done_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Receiver shifts MSB-first so the word reassembles in its original order.
    always @(posedge clk or negedge rst) begin
        if (!rst) lb_sr <= '0;
        else if (qv_m) lb_sr <= {lb_sr[N-2:0], q_m};
    end

    task automatic model_edge(input bit c, input bit lv, input logic [N-1:0] d);
        bit in_word;
        bit rdy;
        in_word  = (qm.size() > 0);
        rdy      = !in_word || (c && qm.size() == 1);
        exp_done = in_word && c && (qm.size() == 1);
        if (in_word && c) begin
            void'(qm.pop_front());
            void'(ql.pop_front());
        end
        if (lv && rdy) begin
            qm.delete();
            ql.delete();
            for (int i = 0; i < N; i++) begin
                qm.push_back(d[N-1-i]);
                ql.push_back(d[i]);
            end
        end
    endtask

    // One clock: drive at negedge, capture load_ready, clock, capture registered outputs.
    task automatic step(input bit c, input bit lv, input logic [N-1:0] d);
        bit r;
        bit hm, hl, vm;
        ce = c;
        load_valid = lv;
        din = d;
        #1;
        r = (qm.size() == 0) || (c && qm.size() == 1);
        exp_ready = {r, r};
        obs_ready = {lr_m, lr_l};
        @(posedge clk);
        model_edge(c, lv, d);
        #1;
        vm = (qm.size() > 0);
        hm = vm ? qm[0] : 1'b0;
        hl = (ql.size() > 0) ? ql[0] : 1'b0;
        exp_out = {hm, vm, vm, exp_done, hl, (ql.size() > 0), (ql.size() > 0), exp_done};
        obs_out = {q_m, qv_m, busy_m, done_m, q_l, qv_l, busy_l, done_l};
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        qm.delete();
        ql.delete();
        exp_done = 1'b0;
        #1;
        obs_out = {q_m, qv_m, busy_m, done_m, q_l, qv_l, busy_l, done_l};
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        ce = 1'b0; load_valid = 1'b0; din = '0;
        apply_reset();
        n_cmp++;
        if (obs_out !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_outputs got %b exp %b", obs_out, 8'h00);
        end
        release_reset();
        #1;
        n_cmp++;
        if ({lr_m, lr_l} !== 2'b11) begin
            n_bad++;
            $display("FAIL reset_load_ready got %b exp 11", {lr_m, lr_l});
        end
    endtask

    // Single word with ce=1: both orders, explicit bit sequence and done position.
    task automatic test_word(input logic [N-1:0] w);
        logic [N-1:0] seq_m, seq_l;
        int done_at;
        seq_m = '0; seq_l = '0; done_at = -1;
        for (int k = 0; k < N + 3; k++) begin
            step(1'b1, (k == 0), (k == 0) ? w : 4'b0000);
            n_cmp++;
            if (obs_ready !== exp_ready) begin
                n_bad++;
                $display("FAIL word_%b cyc%0d load_ready got %b exp %b", w, k, obs_ready, exp_ready);
            end
            n_cmp++;
            if (obs_out !== exp_out) begin
                n_bad++;
                $display("FAIL word_%b cyc%0d outputs got %b exp %b", w, k, obs_out, exp_out);
            end
            if (k < N) begin
                seq_m[N-1-k] = obs_out[7];
                seq_l[k]     = obs_out[3];
            end
            if (obs_out[4] && done_at < 0) done_at = k;
        end
        n_cmp++;
        if (seq_m !== w) begin
            n_bad++;
            $display("FAIL word_msb_seq got %b exp %b", seq_m, w);
        end
        n_cmp++;
        if (seq_l !== w) begin
            n_bad++;
            $display("FAIL word_lsb_seq got %b exp %b", seq_l, w);
        end
        n_cmp++;
        if (done_at !== N) begin
            n_bad++;
            $display("FAIL word_done_cycle got %0d exp %0d", done_at, N);
        end
    endtask

    // Alternating ce starting at 0: each bit held two cycles.
    task automatic test_ce_toggle();
        int qv_cnt, done_cnt;
        qv_cnt = 0; done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            step((k > 0) && (k % 2 == 0), (k == 0), 4'b1010);
            n_cmp++;
            if (obs_ready !== exp_ready) begin
                n_bad++;
                $display("FAIL ce_toggle cyc%0d load_ready got %b exp %b", k, obs_ready, exp_ready);
            end
            n_cmp++;
            if (obs_out !== exp_out) begin
                n_bad++;
                $display("FAIL ce_toggle cyc%0d outputs got %b exp %b", k, obs_out, exp_out);
            end
            qv_cnt   += obs_out[6];
            done_cnt += obs_out[4];
        end
        n_cmp++;
        if (qv_cnt !== 2 * N) begin
            n_bad++;
            $display("FAIL ce_toggle_qvalid_cycles got %0d exp %0d", qv_cnt, 2 * N);
        end
        n_cmp++;
        if (done_cnt !== 1) begin
            n_bad++;
            $display("FAIL ce_toggle_done_count got %0d exp 1", done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [2*N-1:0] seq;
        logic [11:0] done_mask;
        int qv_cnt;
        seq = '0; done_mask = '0; qv_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            step(1'b1, (k <= N), (k == 0) ? 4'b1010 : 4'b0110);
            n_cmp++;
            if (obs_ready !== exp_ready) begin
                n_bad++;
                $display("FAIL b2b cyc%0d load_ready got %b exp %b", k, obs_ready, exp_ready);
            end
            n_cmp++;
            if (obs_out !== exp_out) begin
                n_bad++;
                $display("FAIL b2b cyc%0d outputs got %b exp %b", k, obs_out, exp_out);
            end
            if (k < 2 * N) seq[2*N-1-k] = obs_out[7];
            done_mask[k] = obs_out[4];
            qv_cnt += obs_out[6];
        end
        n_cmp++;
        if (seq !== 8'b1010_0110) begin
            n_bad++;
            $display("FAIL b2b_seq got %b exp %b", seq, 8'b1010_0110);
        end
        n_cmp++;
        if (done_mask !== 12'b0001_0001_0000) begin
            n_bad++;
            $display("FAIL b2b_done_cycles got %b exp %b", done_mask, 12'b0001_0001_0000);
        end
        n_cmp++;
        if (qv_cnt !== 2 * N) begin
            n_bad++;
            $display("FAIL b2b_qvalid_cycles got %0d exp %0d", qv_cnt, 2 * N);
        end
    endtask

    // Load attempts while busy are ignored; then reset mid-word and restart.
    task automatic test_ignore_and_abort();
        logic [N-1:0] seq;
        seq = '0;
        for (int k = 0; k < N + 2; k++) begin
            step(1'b1, (k < 3), (k == 0) ? 4'b1010 : 4'b1111);
            n_cmp++;
            if (obs_out !== exp_out) begin
                n_bad++;
                $display("FAIL ignore cyc%0d outputs got %b exp %b", k, obs_out, exp_out);
            end
            if (k < N) seq[N-1-k] = obs_out[7];
        end
        n_cmp++;
        if (seq !== 4'b1010) begin
            n_bad++;
            $display("FAIL ignore_seq got %b exp 1010", seq);
        end
        step(1'b1, 1'b1, 4'b1100);
        step(1'b1, 1'b0, 4'b0000);
        apply_reset();
        n_cmp++;
        if (obs_out !== 8'h00) begin
            n_bad++;
            $display("FAIL abort_outputs got %b exp %b", obs_out, 8'h00);
        end
        release_reset();
        seq = '0;
        for (int k = 0; k < N + 2; k++) begin
            step(1'b1, (k == 0), 4'b0011);
            n_cmp++;
            if (obs_out !== exp_out) begin
                n_bad++;
                $display("FAIL restart cyc%0d outputs got %b exp %b", k, obs_out, exp_out);
            end
            if (k < N) seq[N-1-k] = obs_out[7];
        end
        n_cmp++;
        if (seq !== 4'b0011) begin
            n_bad++;
            $display("FAIL restart_seq got %b exp 0011", seq);
        end
    endtask

    task automatic test_loopback();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < N + 3; k++) begin
            step(1'b1, (k == 0), 4'b1001);
            if (obs_out[4] && !seen) begin
                seen = 1'b1;
                n_cmp++;
                if (lb_sr !== 4'b1001) begin
                    n_bad++;
                    $display("FAIL loopback_word got %b exp 1001", lb_sr);
                end
            end
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL loopback_done got none exp one pulse");
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), 4'($urandom));
            n_cmp++;
            if (obs_ready !== exp_ready) begin
                n_bad++;
                $display("FAIL random cyc%0d load_ready got %b exp %b", k, obs_ready, exp_ready);
            end
            n_cmp++;
            if (obs_out !== exp_out) begin
                n_bad++;
                $display("FAIL random cyc%0d outputs got %b exp %b", k, obs_out, exp_out);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        exp_done = 1'b0;
        rst = 1'b0;
        ce = 1'b0;
        load_valid = 1'b0;
        din = '0;
        @(negedge clk);
        test_reset();
        test_word(4'b1010);
        test_word(4'b1100);
        test_ce_toggle();
        test_back_to_back();
        test_ignore_and_abort();
        test_loopback();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
